// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel countdown timer.
// The load clamp lives here so every channel sees the same rule.
package timer_pkg;

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_PAUSE, T_DONE} timer_state_t;

    localparam int unsigned SEC_MAX = 59;

    // Returns {min, sec}. Oversized minutes saturate to max_min:00; otherwise
    // seconds saturate to SEC_MAX.
    function automatic logic [15:0] clamp_load(input logic [7:0]  min,
                                               input logic [7:0]  sec,
                                               input int unsigned max_min);
        logic [15:0] res;
        if (32'(min) > max_min) begin
            res = {8'(max_min), 8'd0};
        end else if (32'(sec) > SEC_MAX) begin
            res = {min, 8'(SEC_MAX)};
        end else begin
            res = {min, sec};
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One MM:SS countdown channel: IDLE/RUN/PAUSE/DONE state, optional auto-reload,
// sticky done flag and a one-clk expiry pulse.
module timer_channel
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_i,
    input  logic       set_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       clear_i,
    input  logic       reload_i,
    input  logic [7:0] load_min_i,
    input  logic [7:0] load_sec_i,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic       running_o,
    output logic       done_o,
    output logic       pulse_o
);

    timer_state_t state_q, state_d;
    logic [7:0]   min_q, min_d, sec_q, sec_d;
    logic [7:0]   rl_min_q, rl_min_d, rl_sec_q, rl_sec_d;
    logic         reload_q, reload_d, done_q, done_d, pulse_q, pulse_d;
    logic         is_zero, is_last;

    assign is_zero = (min_q == 8'd0) && (sec_q == 8'd0);
    assign is_last = (min_q == 8'd0) && (sec_q == 8'd1);

    // Any command addressed to this channel consumes the tick of that cycle.
    always_comb begin
        state_d  = state_q;
        min_d    = min_q;
        sec_d    = sec_q;
        rl_min_d = rl_min_q;
        rl_sec_d = rl_sec_q;
        reload_d = reload_q;
        done_d   = done_q;
        pulse_d  = 1'b0;
        if (set_i) begin
            state_d  = T_IDLE;
            done_d   = 1'b0;
            min_d    = load_min_i;
            sec_d    = load_sec_i;
            rl_min_d = load_min_i;
            rl_sec_d = load_sec_i;
            reload_d = reload_i;
        end else if (start_i) begin
            if ((state_q == T_IDLE && !is_zero) || state_q == T_PAUSE) begin
                state_d = T_RUN;
            end
        end else if (stop_i) begin
            if (state_q == T_RUN) begin
                state_d = T_PAUSE;
            end
        end else if (clear_i) begin
            done_d = 1'b0;
            if (state_q == T_DONE) begin
                state_d = T_IDLE;
            end
        end else if (tick_i && state_q == T_RUN) begin
            if (is_last) begin
                done_d  = 1'b1;
                pulse_d = 1'b1;
                if (reload_q) begin
                    min_d = rl_min_q;
                    sec_d = rl_sec_q;
                end else begin
                    min_d   = 8'd0;
                    sec_d   = 8'd0;
                    state_d = T_DONE;
                end
            end else if (sec_q != 8'd0) begin
                sec_d = sec_q - 8'd1;
            end else if (min_q != 8'd0) begin
                min_d = min_q - 8'd1;
                sec_d = 8'(SEC_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= T_IDLE;
            min_q    <= 8'd0;
            sec_q    <= 8'd0;
            rl_min_q <= 8'd0;
            rl_sec_q <= 8'd0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            rl_min_q <= rl_min_d;
            rl_sec_q <= rl_sec_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            pulse_q  <= pulse_d;
        end
    end

    assign min_o     = min_q;
    assign sec_o     = sec_q;
    assign running_o = (state_q == T_RUN);
    assign done_o    = done_q;
    assign pulse_o   = pulse_q;

endmodule

// File: rtl/multi_timer_handler.sv
// NUM_CH countdown timers behind one shared command port, counted by a 1 Hz tick.
// Decodes ch_sel, clamps the load value and packs per-channel outputs.
module multi_timer_handler
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MAX_MIN = 10,
    parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [CH_W-1:0]     ch_sel,
    input  logic                set_timer,
    input  logic                start_timer,
    input  logic                stop_timer,
    input  logic                clear_done,
    input  logic                reload_mode,
    input  logic [7:0]          input_min,
    input  logic [7:0]          input_sec,
    output logic [8*NUM_CH-1:0] timer_min,
    output logic [8*NUM_CH-1:0] timer_sec,
    output logic [NUM_CH-1:0]   timer_running,
    output logic [NUM_CH-1:0]   timer_done,
    output logic [NUM_CH-1:0]   done_pulse,
    output logic                any_done
);

    logic [15:0] load_val;
    logic        sel_ok;

    assign load_val = clamp_load(input_min, input_sec, MAX_MIN);
    // Out-of-range selects address no channel at all.
    assign sel_ok   = (32'(ch_sel) < NUM_CH);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic hit;
        assign hit = sel_ok && (ch_sel == CH_W'(k));

        timer_channel u_channel (
            .clk        (clk),
            .reset      (reset),
            .tick_i     (tick),
            .set_i      (hit && set_timer),
            .start_i    (hit && start_timer),
            .stop_i     (hit && stop_timer),
            .clear_i    (hit && clear_done),
            .reload_i   (reload_mode),
            .load_min_i (load_val[15:8]),
            .load_sec_i (load_val[7:0]),
            .min_o      (timer_min[8*k +: 8]),
            .sec_o      (timer_sec[8*k +: 8]),
            .running_o  (timer_running[k]),
            .done_o     (timer_done[k]),
            .pulse_o    (done_pulse[k])
        );
    end

    assign any_done = |timer_done;

endmodule

// File: tb/tb_multi_timer_handler.sv
// Bench for multi_timer_handler: a table of vectors, directed corner sequences and
// random traffic, all checked against a seconds-based reference model.
module tb_multi_timer_handler;

    localparam int NUM_CH  = 5;
    localparam int MAX_MIN = 10;
    localparam int CH_W    = $clog2(NUM_CH);

    logic                clk = 1'b0;
    logic                reset;
    logic                tick;
    logic [CH_W-1:0]     ch_sel;
    logic                set_timer, start_timer, stop_timer, clear_done, reload_mode;
    logic [7:0]          input_min, input_sec;
    logic [8*NUM_CH-1:0] timer_min, timer_sec;
    logic [NUM_CH-1:0]   timer_running, timer_done, done_pulse;
    logic                any_done;

    always #5 clk = ~clk;

    multi_timer_handler #(
        .NUM_CH  (NUM_CH),
        .MAX_MIN (MAX_MIN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .ch_sel        (ch_sel),
        .set_timer     (set_timer),
        .start_timer   (start_timer),
        .stop_timer    (stop_timer),
        .clear_done    (clear_done),
        .reload_mode   (reload_mode),
        .input_min     (input_min),
        .input_sec     (input_sec),
        .timer_min     (timer_min),
        .timer_sec     (timer_sec),
        .timer_running (timer_running),
        .timer_done    (timer_done),
        .done_pulse    (done_pulse),
        .any_done      (any_done)
    );

    // Reference model: remaining time kept as total seconds; mode is a letter I/R/P/D.
    logic [7:0] m_st    [NUM_CH];
    int         m_rem   [NUM_CH];
    int         m_rl    [NUM_CH];
    bit         m_rb    [NUM_CH];
    bit         m_done  [NUM_CH];
    bit         m_pulse [NUM_CH];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int c, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s ch%0d: got %0d, expected %0d", nm, c, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = "I"; m_rem[c] = 0; m_rl[c] = 0;
            m_rb[c] = 0; m_done[c] = 0; m_pulse[c] = 0;
        end
    endfunction

    function automatic void model_step();
        int sel;
        int v;
        sel = int'(ch_sel);
        for (int c = 0; c < NUM_CH; c++) begin
            m_pulse[c] = 0;
            if (sel == c && (set_timer || start_timer || stop_timer || clear_done)) begin
                if (set_timer) begin
                    if (int'(input_min) > MAX_MIN) v = MAX_MIN * 60;
                    else v = int'(input_min) * 60 + ((int'(input_sec) > 59) ? 59 : int'(input_sec));
                    m_rem[c] = v; m_rl[c] = v; m_rb[c] = reload_mode;
                    m_st[c] = "I"; m_done[c] = 0;
                end else if (start_timer) begin
                    if ((m_st[c] == "I" && m_rem[c] != 0) || m_st[c] == "P") m_st[c] = "R";
                end else if (stop_timer) begin
                    if (m_st[c] == "R") m_st[c] = "P";
                end else begin
                    m_done[c] = 0;
                    if (m_st[c] == "D") m_st[c] = "I";
                end
            end else if (tick && m_st[c] == "R") begin
                if (m_rem[c] == 1) begin
                    m_done[c] = 1; m_pulse[c] = 1;
                    if (m_rb[c]) m_rem[c] = m_rl[c];
                    else begin m_rem[c] = 0; m_st[c] = "D"; end
                end else begin
                    m_rem[c] = m_rem[c] - 1;
                end
            end
        end
    endfunction

    task automatic check_model();
        bit anyd;
        anyd = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            chk("min", c, int'(timer_min[8*c +: 8]), m_rem[c] / 60);
            chk("sec", c, int'(timer_sec[8*c +: 8]), m_rem[c] % 60);
            chk("running", c, int'(timer_running[c]), int'(m_st[c] == "R"));
            chk("done", c, int'(timer_done[c]), int'(m_done[c]));
            chk("pulse", c, int'(done_pulse[c]), int'(m_pulse[c]));
            anyd |= m_done[c];
        end
        chk("any_done", 0, int'(any_done), int'(anyd));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare 1 ns later.
    task automatic drv(input int sel, input bit s, input bit go, input bit sp, input bit cl,
                       input bit rm, input int mn, input int sc, input bit tk);
        ch_sel = CH_W'(sel); set_timer = s; start_timer = go; stop_timer = sp;
        clear_done = cl; reload_mode = rm; input_min = 8'(mn); input_sec = 8'(sc); tick = tk;
        @(posedge clk);
        model_step();
        #1;
        check_model();
        set_timer = 0; start_timer = 0; stop_timer = 0; clear_done = 0; tick = 0;
    endtask

    typedef struct {
        int sel; bit s; bit go; bit sp; bit cl; bit rm; bit tk; int mn; int sc;
        int ch; int emin; int esec; bit erun; bit edone;
    } vec_t;

    vec_t tbl [20];
    int   np;

    initial begin
        tbl = '{
            '{1, 1, 0, 0, 0, 0, 0, 25, 40, 1, 10,  0, 0, 0},
            '{1, 1, 0, 0, 0, 0, 0,  0, 75, 1,  0, 59, 0, 0},
            '{1, 1, 0, 0, 0, 0, 0, 10, 61, 1, 10, 59, 0, 0},
            '{1, 1, 0, 0, 0, 0, 0, 11,  0, 1, 10,  0, 0, 0},
            '{1, 1, 0, 0, 0, 0, 0,  3, 20, 1,  3, 20, 0, 0},
            '{1, 0, 1, 0, 0, 0, 1,  0,  0, 1,  3, 20, 1, 0},
            '{0, 0, 0, 0, 0, 0, 1,  0,  0, 1,  3, 19, 1, 0},
            '{3, 1, 0, 0, 0, 0, 1,  0,  2, 1,  3, 18, 1, 0},
            '{1, 0, 0, 1, 0, 0, 1,  0,  0, 1,  3, 18, 0, 0},
            '{0, 0, 0, 0, 0, 0, 1,  0,  0, 1,  3, 18, 0, 0},
            '{1, 0, 1, 0, 0, 0, 0,  0,  0, 1,  3, 18, 1, 0},
            '{1, 1, 1, 0, 0, 0, 0,  0,  2, 1,  0,  2, 0, 0},
            '{1, 0, 1, 0, 0, 0, 0,  0,  0, 1,  0,  2, 1, 0},
            '{0, 0, 0, 0, 0, 0, 1,  0,  0, 1,  0,  1, 1, 0},
            '{0, 0, 0, 0, 0, 0, 1,  0,  0, 1,  0,  0, 0, 1},
            '{1, 0, 1, 0, 0, 0, 1,  0,  0, 1,  0,  0, 0, 1},
            '{5, 1, 0, 0, 0, 0, 0,  2,  0, 1,  0,  0, 0, 1},
            '{1, 0, 0, 0, 1, 0, 0,  0,  0, 1,  0,  0, 0, 0},
            '{1, 1, 0, 0, 0, 0, 0,  0,  0, 1,  0,  0, 0, 0},
            '{1, 0, 1, 0, 0, 0, 0,  0,  0, 1,  0,  0, 0, 0}
        };

        reset = 0; tick = 0; ch_sel = '0; set_timer = 0; start_timer = 0; stop_timer = 0;
        clear_done = 0; reload_mode = 0; input_min = 0; input_sec = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("reset_outputs", 0,
            int'(|{timer_min, timer_sec, timer_running, timer_done, done_pulse, any_done}), 0);
        reset = 1;

        // Table vectors: clamp rules, priority, pause, invalid select, expiry.
        for (int i = 0; i < 20; i++) begin
            drv(tbl[i].sel, tbl[i].s, tbl[i].go, tbl[i].sp, tbl[i].cl, tbl[i].rm,
                tbl[i].mn, tbl[i].sc, tbl[i].tk);
            chk("tbl_min", i, int'(timer_min[8*tbl[i].ch +: 8]), tbl[i].emin);
            chk("tbl_sec", i, int'(timer_sec[8*tbl[i].ch +: 8]), tbl[i].esec);
            chk("tbl_run", i, int'(timer_running[tbl[i].ch]), int'(tbl[i].erun));
            chk("tbl_done", i, int'(timer_done[tbl[i].ch]), int'(tbl[i].edone));
        end

        // 01:05 expires on exactly the 65th tick with a single pulse.
        drv(0, 1, 0, 0, 0, 0, 1, 5, 0);
        drv(0, 0, 1, 0, 0, 0, 0, 0, 0);
        np = 0;
        for (int i = 0; i < 64; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
            np += int'(done_pulse[0]);
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("t1_done_at_64", 0, int'(timer_done[0]), 0);
        chk("t1_sec_at_64", 0, int'(timer_sec[7:0]), 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        np += int'(done_pulse[0]);
        chk("t1_done", 0, int'(timer_done[0]), 1);
        chk("t1_pulses", 0, np, 1);
        chk("t1_running", 0, int'(timer_running[0]), 0);
        chk("t1_value", 0, int'({timer_min[7:0], timer_sec[7:0]}), 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_pulse_gone", 0, int'(done_pulse[0]), 0);

        // Auto-reload 00:03 on ch2: three expiries in nine ticks, never leaves RUN.
        drv(2, 1, 0, 0, 0, 1, 0, 3, 0);
        drv(2, 0, 1, 0, 0, 0, 0, 0, 0);
        np = 0;
        for (int i = 0; i < 9; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
            chk("t3_running", 2, int'(timer_running[2]), 1);
            if (done_pulse[2]) begin
                np++;
                chk("t3_reload_sec", 2, int'(timer_sec[23:16]), 3);
            end
        end
        chk("t3_pulses", 2, np, 3);

        // Stop coinciding with a tick pauses without decrementing.
        drv(0, 1, 0, 0, 0, 0, 0, 10, 0);
        drv(0, 0, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 0, 0, 0, 1);
        chk("t4_stop_sec", 0, int'(timer_sec[7:0]), 10);
        chk("t4_stop_run", 0, int'(timer_running[0]), 0);
        repeat (5) drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_paused_sec", 0, int'(timer_sec[7:0]), 10);
        drv(0, 0, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_resume_sec", 0, int'(timer_sec[7:0]), 9);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t4_zero_start", 0, int'(timer_running[0]), 0);

        // A set on ch3 eats its tick while ch0 keeps counting.
        drv(0, 1, 0, 0, 0, 0, 5, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0, 0, 0);
        drv(3, 1, 0, 0, 0, 0, 2, 0, 0);
        drv(3, 0, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        drv(3, 1, 0, 0, 0, 0, 1, 11, 1);
        chk("t5_ch3_sec", 3, int'(timer_sec[31:24]), 11);
        chk("t5_ch3_run", 3, int'(timer_running[3]), 0);
        chk("t5_ch0_val", 0, int'(timer_min[7:0]) * 60 + int'(timer_sec[7:0]), 298);
        drv(NUM_CH, 1, 0, 0, 0, 0, 7, 7, 0);
        drv(NUM_CH, 0, 1, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-count clears everything before the next edge.
        for (int c = 0; c < NUM_CH; c++) begin
            drv(c, 1, 0, 0, 0, c[0], 1, 0, 0);
            drv(c, 0, 1, 0, 0, 0, 0, 0, 0);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        reset = 0;
        #1;
        chk("t6_async_reset", 0,
            int'(|{timer_min, timer_sec, timer_running, timer_done, done_pulse, any_done}), 0);
        model_reset();
        check_model();
        @(negedge clk);
        reset = 1;
        drv(0, 1, 0, 0, 0, 0, 0, 1, 0);
        drv(0, 0, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_any_done_set", 0, int'(any_done), 1);
        drv(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("t6_done_cleared", 0, int'(timer_done[0]), 0);
        chk("t6_any_done_clr", 0, int'(any_done), 0);

        // Random traffic, including overlapping commands and invalid selects.
        for (int i = 0; i < 3000; i++) begin
            int  sel, mn, sc;
            bit  s, go, sp, cl, rm, tk;
            sel = $urandom_range(0, (1 << CH_W) - 1);
            s   = ($urandom_range(0, 24) == 0);
            go  = ($urandom_range(0, 5) == 0);
            sp  = ($urandom_range(0, 14) == 0);
            cl  = ($urandom_range(0, 14) == 0);
            rm  = $urandom_range(0, 1);
            mn  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : 0;
            sc  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 90) : $urandom_range(0, 6);
            tk  = ($urandom_range(0, 2) == 0);
            drv(sel, s, go, sp, cl, rm, mn, sc, tk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
